vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Pixel-timing source for the VGA path. It sits directly upstream of the sprite generators (ball, paddle) and the top-level RGB/sync drive. It runs the horizontal and vertical scan counters and produces registered row/col coordinates, HSYNC/VSYNC, display-enable, and line/frame strobes. All outputs are mutually aligned, so downstream pixel logic can use them with no extra delay matching.

Parameters:
ACTIVE_COLS, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (cols)
H_SYNC, 96, hsync pulse width (cols)
H_BACK, 48, horizontal back porch (cols)
ACTIVE_ROWS, 480, visible lines per frame
V_FRONT, 10, vertical front porch (rows)
V_SYNC, 2, vsync pulse width (rows)
V_BACK, 33, vertical back porch (rows)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
FRAME_CNT_W, 8, frame counter width (optional feature only)

Ports:
clk  in  1  pixel-domain clock, the single clock of the block
rst  in  1  asynchronous, active-high reset
ce  in  1  pixel advance enable; counters and outputs update only when ce=1
row  out  $clog2(TOTAL_ROWS)+1  current line, 0..TOTAL_ROWS-1
col  out  $clog2(TOTAL_COLS)+1  current pixel, 0..TOTAL_COLS-1
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  display enable: row<ACTIVE_ROWS && col<ACTIVE_COLS
line_start  out  1  one-ce pulse when col==0
frame_start  out  1  one-ce pulse when row==0 && col==0

Behaviour:
- Derived constants: TOTAL_COLS = sum of the H parameters (800); TOTAL_ROWS = sum of the V parameters (525).
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - Internal counters hcnt = 0, vcnt = 0.
  - Outputs: row = 0, col = 0, de = 0, line_start = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_POL (deasserted).
- Counting, on each cycle with ce=1:
  - hcnt increments and wraps from TOTAL_COLS-1 to 0.
  - vcnt increments only on an hcnt wrap, and wraps from TOTAL_ROWS-1 to 0.
- With ce=0, all state and outputs hold.
- Output stage: registered. Each ce cycle loads row/col/de/hsync/vsync/strobes computed from the current (vcnt, hcnt), then the counters advance. Latency from counter to output is 1 ce-cycle.
  - The first ce after reset presents (0,0) with de=1, line_start=1, frame_start=1.
- hsync window: hsync = SYNC_POL iff ACTIVE_COLS+H_FRONT <= col <= ACTIVE_COLS+H_FRONT+H_SYNC-1, i.e. cols 656..751.
- vsync window: vsync = SYNC_POL iff ACTIVE_ROWS+V_FRONT <= row <= ACTIVE_ROWS+V_FRONT+V_SYNC-1, i.e. rows 490..491, for the full lines.
- Strobes:
  - line_start and frame_start are high for exactly one ce-enabled cycle.
  - If ce drops while a strobe is high, the strobe holds until the next ce; downstream logic qualifies strobes with ce.
- Reset mid-frame: asserting rst forces the reset values asynchronously. No partial line is emitted afterwards; counting resumes from (0,0).
- Elaboration check: every timing parameter must be ≥ 1, and SYNC_POL must be 0 or 1. Otherwise elaboration fails.

Optional Feature:
Macro VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output frame_cnt [FRAME_CNT_W-1:0].
  - Resets to 0.
  - Increments in the same ce cycle that frame_start is asserted; the first post-reset frame reads 1.
  - Wraps modulo 2^FRAME_CNT_W.
  - Used by motion logic as a frame tick and count.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 constants (active/porch/sync for both axes, TOTAL_ROWS, TOTAL_COLS);
  - ROW_W and COL_W localparams;
  - a sync-polarity typedef/enum.
- One sub-module, vga_axis_counter, instantiated twice:
  - horizontal instance, enable = ce;
  - vertical instance, enable = ce && horizontal wrap.
- Each instance takes ACTIVE/FRONT/SYNC/BACK and SYNC_POL, and outputs pos, wrap, in_active and sync.

Test Plan:
1. Reset mid-line: run to col 300, assert rst for 3 clk -> immediately row=0, col=0, de=0, hsync=vsync=1. First ce after release -> (0,0), de=1, frame_start=1.
2. Horizontal window, ce=1 constant:
   - hsync=0 for exactly 96 consecutive cycles, cols 656..751.
   - hsync=1 at col 655 and at col 752.
   - de=0 for cols 640..799.
3. Wrap: (row 5, col 799) -> next (6, 0) with line_start=1. (524, 799) -> (0, 0) with frame_start=1. frame_start period = 420000 ce cycles.
4. Vertical window: vsync=0 for exactly 1600 ce cycles (rows 490..491). de=0 for all of rows 480..524.
5. ce gating: ce=1 every other clk -> outputs constant across ce=0 cycles; frame period = 840000 clk. SYNC_POL=1 run -> hsync/vsync polarity inverted, identical timing.
6. With VGA_TIMING_FRAME_CNT_EN and FRAME_CNT_W=2: frame_cnt reads 1, 2, 3, 0 on successive frame_start strobes, and resets to 0 on rst.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_H_FRONT     = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BACK      = 48;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_V_FRONT     = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BACK      = 33;
  localparam int DEF_FRAME_CNT_W = 8;

  localparam int DEF_TOTAL_COLS =
    DEF_ACTIVE_COLS + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_TOTAL_ROWS =
    DEF_ACTIVE_ROWS + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int COL_W = $clog2(DEF_TOTAL_COLS) + 1;
  localparam int ROW_W = $clog2(DEF_TOTAL_ROWS) + 1;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  // Level to drive on a sync pin given its polarity and window state.
  function automatic logic sync_drive(input sync_pol_e pol,
                                      input logic      in_win);
    return in_win ? logic'(pol) : ~logic'(pol);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter plus active and sync window decode.
// Used once for columns and once for rows.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = DEF_ACTIVE_COLS,
  parameter int FRONT    = DEF_H_FRONT,
  parameter int SYNC     = DEF_H_SYNC,
  parameter int BACK     = DEF_H_BACK,
  parameter int SYNC_POL = 0,
  parameter int W        = $clog2(ACTIVE + FRONT + SYNC + BACK) + 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_pos,
  output logic         o_wrap,
  output logic         o_in_active,
  output logic         o_sync
);

  localparam int TOTAL      = ACTIVE + FRONT + SYNC + BACK;
  localparam int SYNC_START = ACTIVE + FRONT;
  localparam int SYNC_END   = ACTIVE + FRONT + SYNC - 1;

  localparam sync_pol_e POL =
    (SYNC_POL == 1) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;

  logic [W-1:0] r_pos;
  logic         w_in_sync;

  // Position counter, wraps at the end of the axis.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos <= '0;
    end else if (i_en) begin
      r_pos <= o_wrap ? '0 : r_pos + W'(1);
    end
  end

  // Window decode from the current position.
  always_comb begin
    o_wrap      = (r_pos == W'(TOTAL - 1));
    o_in_active = (r_pos < W'(ACTIVE));
    w_in_sync   = (r_pos >= W'(SYNC_START)) &&
                  (r_pos <= W'(SYNC_END));
    o_sync      = sync_drive(POL, w_in_sync);
  end

  assign o_pos = r_pos;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan timing: registered row/col, syncs, display enable, strobes.
// Optional frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int SYNC_POL    = 0,
  parameter int FRAME_CNT_W = DEF_FRAME_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  output logic [$clog2(ACTIVE_ROWS+V_FRONT+V_SYNC+V_BACK):0] row,
  output logic [$clog2(ACTIVE_COLS+H_FRONT+H_SYNC+H_BACK):0] col,
  output logic hsync,
  output logic vsync,
  output logic de,
  output logic line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`else
  output logic frame_start
`endif
);

  localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
  localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
  localparam int CW = $clog2(TOTAL_COLS) + 1;
  localparam int RW = $clog2(TOTAL_ROWS) + 1;

  localparam sync_pol_e POL =
    (SYNC_POL == 1) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
  localparam logic SYNC_IDLE = sync_drive(POL, 1'b0);

  // Reject degenerate timings and bad polarity at elaboration.
  if (ACTIVE_COLS < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      ACTIVE_ROWS < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      FRAME_CNT_W < 1) begin : g_bad_timing
    $fatal(1, "vga_timing_gen: timing parameters must be >= 1");
  end
  if (SYNC_POL != int'(SYNC_ACTIVE_LOW) &&
      SYNC_POL != int'(SYNC_ACTIVE_HIGH)) begin : g_bad_pol
    $fatal(1, "vga_timing_gen: SYNC_POL must be 0 or 1");
  end

  logic [CW-1:0] w_hpos;
  logic [RW-1:0] w_vpos;
  logic          w_h_wrap;
  logic          w_unused_v_wrap;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_h_sync;
  logic          w_v_sync;
  logic          w_v_en;
  logic          w_line_first;
  logic          w_frame_first;

  // Rows advance only when the column counter rolls over.
  assign w_v_en = ce & w_h_wrap;

  vga_axis_counter #(
    .ACTIVE   (ACTIVE_COLS),
    .FRONT    (H_FRONT),
    .SYNC     (H_SYNC),
    .BACK     (H_BACK),
    .SYNC_POL (SYNC_POL),
    .W        (CW)
  ) u_h (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (ce),
    .o_pos       (w_hpos),
    .o_wrap      (w_h_wrap),
    .o_in_active (w_h_act),
    .o_sync      (w_h_sync)
  );

  vga_axis_counter #(
    .ACTIVE   (ACTIVE_ROWS),
    .FRONT    (V_FRONT),
    .SYNC     (V_SYNC),
    .BACK     (V_BACK),
    .SYNC_POL (SYNC_POL),
    .W        (RW)
  ) u_v (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (w_v_en),
    .o_pos       (w_vpos),
    .o_wrap      (w_unused_v_wrap),
    .o_in_active (w_v_act),
    .o_sync      (w_v_sync)
  );

  // Strobe decode of the counter position about to be presented.
  always_comb begin
    w_line_first  = (w_hpos == '0);
    w_frame_first = w_line_first && (w_vpos == '0);
  end

  // Output stage: all outputs load together so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      de          <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      row         <= w_vpos;
      col         <= w_hpos;
      de          <= w_h_act & w_v_act;
      hsync       <= w_h_sync;
      vsync       <= w_v_sync;
      line_start  <= w_line_first;
      frame_start <= w_frame_first;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Frame count ticks together with the frame_start load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (ce && w_frame_first) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus two
// small-geometry instances (active-low and active-high sync).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- default-geometry instance ----------------
  logic             rst_a, ce_a;
  logic [ROW_W-1:0] row_a;
  logic [COL_W-1:0] col_a;
  logic hs_a, vs_a, de_a, ls_a, fs_a;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fc_a;
`endif

  vga_timing_gen u_a (
    .clk         (clk),
    .rst         (rst_a),
    .ce          (ce_a),
    .row         (row_a),
    .col         (col_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .de          (de_a),
    .line_start  (ls_a),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start (fs_a),
    .frame_cnt   (fc_a)
`else
    .frame_start (fs_a)
`endif
  );

  // ---------------- small-geometry instances ----------------
  // 15 cols (8 active, hsync 10..12), 8 rows (4 active, vsync 5..6).
  logic       rst_b, ce_b;
  logic [3:0] row_b, row_c;
  logic [4:0] col_b, col_c;
  logic hs_b, vs_b, de_b, ls_b, fs_b;
  logic hs_c, vs_c, de_c, ls_c, fs_c;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [1:0] fc_b, fc_c;
`endif

  vga_timing_gen #(
    .ACTIVE_COLS (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .ACTIVE_ROWS (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .SYNC_POL (0), .FRAME_CNT_W (2)
  ) u_b (
    .clk         (clk),
    .rst         (rst_b),
    .ce          (ce_b),
    .row         (row_b),
    .col         (col_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .de          (de_b),
    .line_start  (ls_b),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start (fs_b),
    .frame_cnt   (fc_b)
`else
    .frame_start (fs_b)
`endif
  );

  vga_timing_gen #(
    .ACTIVE_COLS (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .ACTIVE_ROWS (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1),
    .SYNC_POL (1), .FRAME_CNT_W (2)
  ) u_c (
    .clk         (clk),
    .rst         (rst_b),
    .ce          (ce_b),
    .row         (row_c),
    .col         (col_c),
    .hsync       (hs_c),
    .vsync       (vs_c),
    .de          (de_c),
    .line_start  (ls_c),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_start (fs_c),
    .frame_cnt   (fc_c)
`else
    .frame_start (fs_c)
`endif
  );

  typedef struct packed {
    logic [3:0] row;
    logic [4:0] col;
    logic de, hs, vs, ls, fs;
  } obs_t;

  obs_t obs_b, obs_c;
  assign obs_b = {row_b, col_b, de_b, hs_b, vs_b, ls_b, fs_b};
  assign obs_c = {row_c, col_c, de_c, hs_c, vs_c, ls_c, fs_c};

  // Expected small-geometry outputs after m ce-cycles since reset.
  function automatic obs_t mdl(input int m, input logic pol);
    obs_t o;
    int k, c, r;
    o = '0;
    o.hs = ~pol;
    o.vs = ~pol;
    if (m > 0) begin
      k = (m - 1) % 120;
      c = k % 15;
      r = k / 15;
      o.row = 4'(r);
      o.col = 5'(c);
      o.de  = (r < 4) && (c < 8);
      o.hs  = (c >= 10 && c <= 12) ? pol : ~pol;
      o.vs  = (r >= 5 && r <= 6) ? pol : ~pol;
      o.ls  = (c == 0);
      o.fs  = (k == 0);
    end
    return o;
  endfunction

  function automatic int mdl_fc(input int m);
    return (m == 0) ? 0 : (((m - 1) / 120) + 1) % 4;
  endfunction

  typedef struct {
    int   t;
    int   row;
    int   col;
    logic de, hs, vs, ls, fs;
  } vec_t;

  vec_t tab[13];

  function automatic vec_t mkv(input int t, input int r, input int c,
                               input logic de, input logic hs,
                               input logic vs, input logic ls,
                               input logic fs);
    vec_t v;
    v.t = t; v.row = r; v.col = c;
    v.de = de; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input int r, input int c,
                       input logic de, input logic hs, input logic vs,
                       input logic ls, input logic fs);
    chk({nm, " row"}, 64'(row_a), 64'(r));
    chk({nm, " col"}, 64'(col_a), 64'(c));
    chk({nm, " de"}, 64'(de_a), 64'(de));
    chk({nm, " hsync"}, 64'(hs_a), 64'(hs));
    chk({nm, " vsync"}, 64'(vs_a), 64'(vs));
    chk({nm, " line_start"}, 64'(ls_a), 64'(ls));
    chk({nm, " frame_start"}, 64'(fs_a), 64'(fs));
  endtask

  task automatic chk_bc(input string nm, input int m);
    chk($sformatf("%s B m=%0d", nm, m), 64'(obs_b), 64'(mdl(m, 1'b0)));
    chk($sformatf("%s C m=%0d", nm, m), 64'(obs_c), 64'(mdl(m, 1'b1)));
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk($sformatf("%s fcnt m=%0d", nm, m), 64'(fc_b), 64'(mdl_fc(m)));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, m, hs_low, first_low, last_low, de_low;
    int last_fs, vs_low, de_cnt, hs_c_hi;

    tab[0]  = mkv(1,    0, 0,   1, 1, 1, 1, 1);
    tab[1]  = mkv(2,    0, 1,   1, 1, 1, 0, 0);
    tab[2]  = mkv(640,  0, 639, 1, 1, 1, 0, 0);
    tab[3]  = mkv(641,  0, 640, 0, 1, 1, 0, 0);
    tab[4]  = mkv(656,  0, 655, 0, 1, 1, 0, 0);
    tab[5]  = mkv(657,  0, 656, 0, 0, 1, 0, 0);
    tab[6]  = mkv(752,  0, 751, 0, 0, 1, 0, 0);
    tab[7]  = mkv(753,  0, 752, 0, 1, 1, 0, 0);
    tab[8]  = mkv(800,  0, 799, 0, 1, 1, 0, 0);
    tab[9]  = mkv(801,  1, 0,   1, 1, 1, 1, 0);
    tab[10] = mkv(4800, 5, 799, 0, 1, 1, 0, 0);
    tab[11] = mkv(4801, 6, 0,   1, 1, 1, 1, 0);
    tab[12] = mkv(4802, 6, 1,   1, 1, 1, 0, 0);

    rst_a = 1'b1; ce_a = 1'b0;
    rst_b = 1'b1; ce_b = 1'b0;
    tick();
    tick();

    // Reset state of all instances.
    chk_a("reset", 0, 0, 0, 1, 1, 0, 0);
    chk_bc("reset", 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("reset fcnt A", 64'(fc_a), 64'd0);
`endif

    // Default geometry, continuous ce, table of key positions.
    rst_a = 1'b0;
    ce_a  = 1'b1;
    t = 0; hs_low = 0; first_low = 0; last_low = 0; de_low = 0;
    for (int i = 0; i < 13; i++) begin
      while (t < tab[i].t) begin
        tick();
        t++;
        if (t <= 800) begin
          if (!hs_a) begin
            hs_low++;
            if (first_low == 0) first_low = t;
            last_low = t;
          end
          if (!de_a) de_low++;
        end
      end
      chk_a($sformatf("vec t=%0d", tab[i].t), tab[i].row, tab[i].col,
            tab[i].de, tab[i].hs, tab[i].vs, tab[i].ls, tab[i].fs);
    end
    chk("hsync low count", 64'(hs_low), 64'd96);
    chk("hsync low span", 64'(last_low - first_low), 64'd95);
    chk("de low count line0", 64'(de_low), 64'd160);

    // Run to row 6 col 300, then reset mid-line.
    while (t < 5101) begin
      tick();
      t++;
    end
    chk("pre-reset col", 64'(col_a), 64'd300);
    #2;
    rst_a = 1'b1;
    #1;
    chk_a("async reset", 0, 0, 0, 1, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_a("reset held", 0, 0, 0, 1, 1, 0, 0);
    rst_a = 1'b0;
    ce_a  = 1'b0;
    tick();
    tick();
    chk_a("idle after reset", 0, 0, 0, 1, 1, 0, 0);
    ce_a = 1'b1;
    tick();
    chk_a("first ce", 0, 0, 1, 1, 1, 1, 1);
    ce_a = 1'b0;
    tick();
    chk_a("strobe hold", 0, 0, 1, 1, 1, 1, 1);
    ce_a = 1'b1;
    tick();
    chk_a("second ce", 0, 1, 1, 1, 1, 0, 0);
    ce_a = 1'b0;

    // Small geometry, continuous ce, four frames.
    rst_b = 1'b0;
    ce_b  = 1'b1;
    m = 0; last_fs = -1; vs_low = 0; de_cnt = 0; hs_c_hi = 0;
    for (int i = 1; i <= 480; i++) begin
      tick();
      m++;
      chk_bc("run", m);
      if (fs_b) begin
        if (last_fs >= 0)
          chk("frame period ce", 64'(i - last_fs), 64'd120);
        last_fs = i;
      end
      if (i <= 120) begin
        if (!vs_b) vs_low++;
        if (de_b) de_cnt++;
        if (hs_c) hs_c_hi++;
      end
    end
    chk("vsync low per frame", 64'(vs_low), 64'd30);
    chk("de per frame", 64'(de_cnt), 64'd32);
    chk("hsync high C", 64'(hs_c_hi), 64'd24);

    // ce every other clock: outputs hold, period doubles.
    last_fs = -1;
    for (int i = 1; i <= 480; i++) begin
      ce_b = (i % 2 == 1);
      tick();
      if (ce_b) m++;
      chk_bc("gated", m);
      if (ce_b && fs_b) begin
        if (last_fs >= 0)
          chk("frame period clk", 64'(i - last_fs), 64'd240);
        last_fs = i;
      end
    end

    // Mid-frame reset on the small instances.
    ce_b = 1'b1;
    repeat (37) begin
      tick();
      m++;
    end
    chk_bc("pre-reset", m);
    #2;
    rst_b = 1'b1;
    #1;
    chk_bc("async reset", 0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    m = 0;
    tick();
    m++;
    chk_bc("restart", m);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
